// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_SRC valid/ready producers.
// A grant lasts up to MAX_BURST words; full stalls the grant without releasing it.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [NUM_SRC*DWIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  output logic [DWIDTH-1:0]         fifo_data_o,
  output logic                      fifo_wrreq_o,
  input  logic                      fifo_full_i,
  output logic [NUM_SRC-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;

  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic                xfer;
  logic                rel;

  // Search last+1, last+2, ... wrapping; the current grantee is considered last.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx = (32'(last_q) + i) % NUM_SRC;
      if (!pick_found && src_valid_i[idx[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = idx[IdxW-1:0];
      end
    end
  end

  // last_q always holds the grantee while in StGrant; reset suppresses an in-flight write.
  assign xfer = (state_q == StGrant) & src_valid_i[last_q] & ~fifo_full_i & ~srst_i;
  assign rel  = (xfer && (burst_cnt_q == CntW'(MAX_BURST - 1))) || !src_valid_i[last_q];

  assign src_ready_o  = xfer ? grant_q : '0;
  assign fifo_wrreq_o = xfer;
  assign fifo_data_o  = src_data_i[last_q*DWIDTH +: DWIDTH];
  assign grant_o      = grant_q;
  assign busy_o       = (state_q == StGrant);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StGrant;
          grant_d     = NUM_SRC'(1) << pick_idx;
          last_d      = pick_idx;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
        end
        if (rel) begin
          burst_cnt_d = '0;
          if (pick_found) begin
            grant_d = NUM_SRC'(1) << pick_idx;
            last_d  = pick_idx;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= IdxW'(NUM_SRC - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer models plus a rule-level arbiter model compared
// every cycle, with directed scenarios pinned by literal expectations.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         srst;
  logic [N*W-1:0] src_data;
  logic [N-1:0] src_valid, src_ready, grant;
  logic [W-1:0] fifo_data;
  logic         fifo_wrreq, fifo_full, busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_SRC(N), .DWIDTH(W), .MAX_BURST(MB)) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .fifo_data_o (fifo_data),
    .fifo_wrreq_o(fifo_wrreq),
    .fifo_full_i (fifo_full),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;

  int seq[N];
  bit en[N];
  bit prev_acc[N];
  int pct = 100;
  int full_pct = 0;
  bit full_force = 1'b0;

  // Model: granted index (-1 idle), most recent grantee, words in this burst.
  int m_g, m_last, m_cnt;

  logic [N-1:0] obs_grant, obs_ready;
  logic         obs_wrreq, obs_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: drive producers, check outputs at negedge, advance model past posedge.
  task automatic step();
    logic [N-1:0] exp_grant, exp_ready;
    bit xfer, rel;
    int p, n_g, n_last, n_cnt;
    for (int k = 0; k < N; k++) begin
      if (prev_acc[k]) seq[k]++;
      if (prev_acc[k] || !src_valid[k] || !en[k])
        src_valid[k] = en[k] && ($urandom_range(99) < pct);
      src_data[k*W +: W] = W'((k << 12) | (seq[k] & 'hfff));
    end
    fifo_full = full_force || ($urandom_range(99) < full_pct);
    @(negedge clk);
    obs_grant = grant;
    obs_ready = src_ready;
    obs_wrreq = fifo_wrreq;
    obs_busy  = busy;
    exp_grant = (m_g < 0) ? '0 : (N'(1) << m_g);
    xfer      = (m_g >= 0) && src_valid[m_g] && !fifo_full && !srst;
    exp_ready = xfer ? exp_grant : '0;
    chk("grant_o", grant, exp_grant);
    chk("busy_o", busy, m_g >= 0);
    chk("fifo_wrreq_o", fifo_wrreq, xfer);
    chk("src_ready_o", src_ready, exp_ready);
    chk("fifo_data_o", fifo_data, src_data[m_last*W +: W]);
    if (xfer) chk("write_order", fifo_data, (m_g << 12) | (seq[m_g] & 'hfff));
    n_g = m_g; n_last = m_last; n_cnt = m_cnt;
    if (srst) begin
      n_g = -1; n_last = N - 1; n_cnt = 0;
    end else if (m_g < 0) begin
      p = pick(m_last, src_valid);
      n_g = p; n_cnt = 0;
      if (p >= 0) n_last = p;
    end else begin
      n_cnt = m_cnt + (xfer ? 1 : 0);
      rel = (xfer && (m_cnt + 1 == MB)) || !src_valid[m_g];
      if (rel) begin
        p = pick(m_last, src_valid);
        n_g = p; n_cnt = 0;
        if (p >= 0) n_last = p;
      end
    end
    for (int k = 0; k < N; k++) prev_acc[k] = xfer && (k == m_g);
    @(posedge clk);
    #1;
    m_g = n_g; m_last = n_last; m_cnt = n_cnt;
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b0; seq[k] = 0; prev_acc[k] = 1'b0;
    end
    full_force = 1'b0; full_pct = 0; pct = 100;
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  initial begin
    int first, last, nw;
    srst = 1'b1; src_valid = '0; src_data = '0; fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b0; seq[k] = 0; prev_acc[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_g = -1; m_last = N - 1; m_cnt = 0;

    // Idle after reset
    do_reset();
    repeat (5) step();
    chk("idle_grant", obs_grant, 0);
    chk("idle_wrreq", obs_wrreq, 0);
    chk("idle_ready", obs_ready, 0);
    chk("idle_busy", obs_busy, 0);

    // Source 2 streams 10 words alone
    do_reset();
    en[2] = 1'b1;
    first = -1; last = -1; nw = 0;
    for (int c = 0; c < 30 && nw < 10; c++) begin
      step();
      if (c == 0) chk("src2_arb_latency", obs_grant, 4'b0000);
      if (c == 1) chk("src2_grant", obs_grant, 4'b0100);
      if (obs_wrreq) begin
        if (first < 0) first = c;
        last = c;
        nw++;
      end
      if (nw == 10) en[2] = 1'b0;
    end
    chk("src2_words", nw, 10);
    chk("src2_first_cycle", first, 1);
    chk("src2_no_bubble", last - first + 1, 10);
    repeat (3) step();

    // All sources continuously valid: 4-word bursts in order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < N; k++) en[k] = 1'b1;
    nw = 0;
    for (int c = 0; c < 60 && nw < 20; c++) begin
      step();
      if (obs_wrreq) begin
        chk("rr_order", idx_of(obs_ready), (nw / MB) % N);
        chk("rr_one_ready", $countones(obs_ready), 1);
        nw++;
      end
    end
    chk("rr_words", nw, 20);

    // Full stall in the middle of source 1's burst
    do_reset();
    en[1] = 1'b1; en[2] = 1'b1;
    step();
    chk("stall_idle", obs_grant, 4'b0000);
    step();
    chk("stall_w1", obs_wrreq, 1);
    step();
    chk("stall_w2", obs_ready, 4'b0010);
    full_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stall_no_wrreq", obs_wrreq, 0);
      chk("stall_no_ready", obs_ready, 0);
      chk("stall_grant_held", obs_grant, 4'b0010);
    end
    full_force = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_resume", obs_ready, 4'b0010);
    end
    step();
    chk("stall_rotate", obs_grant, 4'b0100);

    // Source 0 drops valid after 2 words; source 3 takes over
    do_reset();
    en[0] = 1'b1; en[3] = 1'b1;
    step();
    step();
    chk("drop_w0", obs_ready, 4'b0001);
    step();
    chk("drop_w1", obs_ready, 4'b0001);
    en[0] = 1'b0;
    step();
    chk("drop_release_grant", obs_grant, 4'b0001);
    chk("drop_release_wrreq", obs_wrreq, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drop_src3", obs_ready, 4'b1000);
    end

    // Reset in the middle of a source 2 burst
    do_reset();
    en[2] = 1'b1;
    repeat (3) step();
    en[0] = 1'b1;
    srst = 1'b1;
    step();
    chk("rst_inflight_wrreq", obs_wrreq, 0);
    chk("rst_inflight_ready", obs_ready, 0);
    srst = 1'b0;
    step();
    chk("rst_after_grant", obs_grant, 0);
    chk("rst_after_busy", obs_busy, 0);
    chk("rst_after_wrreq", obs_wrreq, 0);
    step();
    chk("rst_src0_first", obs_grant, 4'b0001);

    // Random traffic, back-pressure and occasional resets
    do_reset();
    for (int k = 0; k < N; k++) en[k] = 1'b1;
    pct = 70; full_pct = 25;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) for (int k = 0; k < N; k++) en[k] = ($urandom_range(3) != 0);
      srst = ($urandom_range(499) == 0);
      step();
    end
    srst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
